// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst-bounded arbiter for a shared FIFO write port
// Optional feature macro: FIFO_WR_ARBITER_STATS_EN adds o_word_count / o_stall_count.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_ack,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_write,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  output logic                          o_busy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [15:0]                   o_word_count,
  output logic [15:0]                   o_stall_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   sel_idx, cand;
  logic               sel_valid;
  logic               xfer, tenure_end;

  // Round-robin pick: first requester after the previous owner, wrapping.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!sel_valid && i_req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and write-side outputs; a tenure always returns to IDLE for one bubble.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    count_d      = count_q;
    gnt_d        = gnt_q;
    xfer         = 1'b0;
    tenure_end   = 1'b0;
    o_fifo_write = 1'b0;
    o_ack        = '0;
    o_fifo_data  = '0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = BUSY;
          owner_d = sel_idx;
          count_d = '0;
          gnt_d   = NUM_REQ'(1) << sel_idx;
        end
      end
      BUSY: begin
        xfer           = i_req[owner_q] & ~i_fifo_full;
        o_fifo_write   = xfer;
        o_ack[owner_q] = xfer;
        o_fifo_data    = i_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        tenure_end     = ~i_req[owner_q] | (xfer & (count_q == CNT_LAST));
        if (xfer) begin
          count_d = count_q + CNT_W'(1);
        end
        if (tenure_end) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = owner_q;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset hands first priority to requester 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_LAST;
      count_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
      gnt_q   <= gnt_d;
    end
  end

  assign o_gnt  = gnt_q;
  assign o_busy = (state_q == BUSY);

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic stall_evt;
  assign stall_evt = (state_q == BUSY) & i_req[owner_q] & i_fifo_full;

  // Saturating counters of written words and full-stalled grant cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_word_count  <= '0;
      o_stall_count <= '0;
    end else begin
      if (o_fifo_write && (o_word_count != 16'hFFFF)) begin
        o_word_count <= o_word_count + 16'd1;
      end
      if (stall_evt && (o_stall_count != 16'hFFFF)) begin
        o_stall_count <= o_stall_count + 16'd1;
      end
    end
  end
`endif

endmodule
